// File: rtl/u111_pkg.sv
// U111 shared definitions: watchdog state encoding,
// default timeout bound and active-low signal levels.
package u111_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_ERROR   = 2'd2,
    ST_RECOVER = 2'd3
  } wd_state_t;

  localparam int TIMEOUT_CLKS_DEF = 256;

  localparam logic ASSERTED = 1'b0;
  localparam logic NEGATED  = 1'b1;

endpackage

// File: rtl/u111_timeout_log.sv
// U111 timeout log: address/direction of the last
// timed-out cycle plus a saturating timeout count.
module u111_timeout_log #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture,
  input  logic [1:0]           addr,
  input  logic                 rnw,
  output logic [1:0]           err_addr,
  output logic                 err_rnw,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr <= '0;
      err_rnw  <= 1'b0;
      err_cnt  <= '0;
    end else if (capture) begin
      err_addr <= addr;
      err_rnw  <= rnw;
      if (err_cnt != '1)
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: rtl/u111_bus_timeout.sv
// U111 bus-cycle watchdog: forces a one-clock TEA when a
// transfer is not acknowledged in time. Log: U111_TIMEOUT_LOG_EN.
module u111_bus_timeout
  import u111_pkg::*;
#(
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
  parameter int CNT_W        = 9,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 CLK40,
  input  logic                 RESET,
  input  logic                 TSn,
  input  logic                 TACKn,
  input  logic                 RnW,
  input  logic [1:0]           A_AMIGA,
  input  logic                 BGn,
  output logic                 TEA_REQn,
  output logic                 BUSY,
  output logic                 OVERLAP,
  output logic [1:0]           ERR_ADDR,
  output logic                 ERR_RNW,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(TIMEOUT_CLKS - 1);

  wd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovl_q, ovl_d;
  logic             tea_q, tea_d;
  logic             take;
  logic             capture;

  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovl_q   <= 1'b0;
      tea_q   <= NEGATED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovl_q   <= ovl_d;
      tea_q   <= tea_d;
    end
  end

  // Ack and bus loss take priority over a restart,
  // which in turn beats the terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovl_d   = ovl_q;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (TSn == ASSERTED && BGn == ASSERTED) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          take    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (BGn == NEGATED) begin
          state_d = ST_IDLE;
        end else if (TACKn == ASSERTED) begin
          state_d = ST_IDLE;
        end else if (TSn == ASSERTED) begin
          cnt_d = '0;
          ovl_d = 1'b1;
          take  = 1'b1;
        end else if (cnt_q == TERM) begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (TACKn == NEGATED && TSn == NEGATED)
          state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    tea_d   = (state_q == ST_ERROR) ? ASSERTED : NEGATED;
    capture = (state_q == ST_ACTIVE) &&
              (state_d == ST_ERROR);
  end

  assign TEA_REQn = tea_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign OVERLAP  = ovl_q;

`ifdef U111_TIMEOUT_LOG_EN
  logic [1:0] addr_q;
  logic       rnw_q;

  always_ff @(posedge CLK40) begin
    if (RESET) begin
      addr_q <= '0;
      rnw_q  <= 1'b0;
    end else if (take) begin
      addr_q <= A_AMIGA;
      rnw_q  <= RnW;
    end
  end

  u111_timeout_log #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_log (
    .clk      (CLK40),
    .rst      (RESET),
    .capture  (capture),
    .addr     (addr_q),
    .rnw      (rnw_q),
    .err_addr (ERR_ADDR),
    .err_rnw  (ERR_RNW),
    .err_cnt  (ERR_CNT)
  );
`else
  logic unused_log;
  assign unused_log = ^{RnW, A_AMIGA, take, capture};
  assign ERR_ADDR   = '0;
  assign ERR_RNW    = 1'b0;
  assign ERR_CNT    = '0;
`endif

endmodule

// File: tb/tb_u111_bus_timeout.sv
// Directed bench for u111_bus_timeout: table vectors
// plus hand sequences for timeout, race, recovery, reset.
module tb_u111_bus_timeout;

`ifdef U111_TIMEOUT_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  localparam int T  = 16;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          tsn, tackn, rnw, bgn;
  logic [1:0]    addr;
  logic          tea_reqn, busy, overlap;
  logic [1:0]    err_addr;
  logic          err_rnw;
  logic [EW-1:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  int   first_low;
  int   nlow;
  logic busy_hist [0:63];

  always #5 clk = ~clk;

  u111_bus_timeout #(
    .TIMEOUT_CLKS (T),
    .CNT_W        (9),
    .ERR_CNT_W    (EW)
  ) dut (
    .CLK40    (clk),
    .RESET    (rst),
    .TSn      (tsn),
    .TACKn    (tackn),
    .RnW      (rnw),
    .A_AMIGA  (addr),
    .BGn      (bgn),
    .TEA_REQn (tea_reqn),
    .BUSY     (busy),
    .OVERLAP  (overlap),
    .ERR_ADDR (err_addr),
    .ERR_RNW  (err_rnw),
    .ERR_CNT  (err_cnt)
  );

  typedef struct {
    logic       tsn;
    logic       tackn;
    logic       bgn;
    logic       rnw;
    logic [1:0] addr;
    logic       busy;
    logic       tea;
    logic       ovl;
  } vec_t;

  vec_t vecs [0:12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic idle_in();
    tsn   = 1'b1;
    tackn = 1'b1;
  endtask

  // TSn on the first edge, then nt edges; optional
  // overlap TSn and ack on given edge numbers.
  task automatic run(input logic [1:0] a,
                     input logic r,
                     input int ovl_at,
                     input int tack_at,
                     input int nt);
    first_low = 0;
    nlow      = 0;
    tsn   = 1'b0;
    tackn = 1'b1;
    addr  = a;
    rnw   = r;
    tick();
    for (int n = 1; n <= nt; n++) begin
      tsn   = (n == ovl_at) ? 1'b0 : 1'b1;
      tackn = (n == tack_at) ? 1'b0 : 1'b1;
      if (n == ovl_at) begin
        addr = ~a;
        rnw  = ~r;
      end else begin
        addr = 2'b00;
        rnw  = 1'b0;
      end
      tick();
      busy_hist[n] = busy;
      if (tea_reqn == 1'b0) begin
        if (first_low == 0) first_low = n;
        nlow++;
      end
    end
    idle_in();
  endtask

  initial begin
    int tea_seen;

    rst   = 1'b1;
    bgn   = 1'b0;
    rnw   = 1'b0;
    addr  = 2'b00;
    idle_in();

    vecs[0]  = '{0, 1, 0, 1, 2'b11, 1, 1, 0};
    vecs[1]  = '{1, 1, 0, 0, 2'b00, 1, 1, 0};
    vecs[2]  = '{1, 1, 0, 0, 2'b00, 1, 1, 0};
    vecs[3]  = '{1, 1, 0, 0, 2'b00, 1, 1, 0};
    vecs[4]  = '{1, 1, 0, 0, 2'b00, 1, 1, 0};
    vecs[5]  = '{1, 0, 0, 0, 2'b00, 0, 1, 0};
    vecs[6]  = '{1, 1, 0, 0, 2'b00, 0, 1, 0};
    vecs[7]  = '{0, 1, 1, 1, 2'b01, 0, 1, 0};
    vecs[8]  = '{1, 1, 1, 0, 2'b00, 0, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 2'b10, 1, 1, 0};
    vecs[10] = '{1, 1, 0, 0, 2'b00, 1, 1, 0};
    vecs[11] = '{1, 1, 1, 0, 2'b00, 0, 1, 0};
    vecs[12] = '{1, 1, 0, 0, 2'b00, 0, 1, 0};

    tick();
    tick();
    chk("rst_tea", tea_reqn, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovl", overlap, 0);
    chk("rst_eaddr", err_addr, 0);
    chk("rst_ernw", err_rnw, 0);
    chk("rst_ecnt", err_cnt, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i <= 12; i++) begin
      tsn   = vecs[i].tsn;
      tackn = vecs[i].tackn;
      bgn   = vecs[i].bgn;
      rnw   = vecs[i].rnw;
      addr  = vecs[i].addr;
      tick();
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_tea", i), tea_reqn, vecs[i].tea);
      chk($sformatf("vec%0d_ovl", i), overlap, vecs[i].ovl);
    end
    idle_in();
    bgn = 1'b0;
    chk("norm_ecnt", err_cnt, 0);

    run(2'b10, 1'b1, 0, 0, 20);
    chk("to_first", first_low, T + 1);
    chk("to_width", nlow, 1);
    chk("to_busy_at_tea", busy_hist[T + 1], 1);
    chk("to_busy_after", busy_hist[T + 2], 0);
    chk("to_eaddr", err_addr, LOG ? 2 : 0);
    chk("to_ernw", err_rnw, LOG ? 1 : 0);
    chk("to_ecnt", err_cnt, LOG ? 1 : 0);

    run(2'b01, 1'b0, 0, T, 20);
    chk("race_tea", nlow, 0);
    chk("race_busy_pre", busy_hist[T - 1], 1);
    chk("race_busy", busy_hist[T], 0);
    chk("race_ecnt", err_cnt, LOG ? 1 : 0);

    run(2'b01, 1'b0, 0, 0, T + 1);
    chk("rec_first", first_low, T + 1);
    for (int i = 0; i < 3; i++) begin
      tackn = 1'b0;
      tsn   = (i == 1) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("rec_hold%0d", i), busy, 1);
    end
    tackn = 1'b1;
    tsn   = 1'b0;
    tick();
    chk("rec_ts_low", busy, 1);
    tsn = 1'b1;
    tick();
    chk("rec_exit", busy, 0);
    tea_seen = 0;
    for (int i = 0; i < T + 4; i++) begin
      tick();
      if (tea_reqn == 1'b0) tea_seen++;
    end
    chk("rec_untimed", tea_seen, 0);
    chk("rec_eaddr", err_addr, LOG ? 1 : 0);
    chk("rec_ecnt", err_cnt, LOG ? 2 : 0);

    run(2'b10, 1'b1, 5, 0, 26);
    chk("ovl_flag", overlap, 1);
    chk("ovl_first", first_low, 5 + T + 1);
    chk("ovl_width", nlow, 1);
    chk("ovl_eaddr", err_addr, LOG ? 1 : 0);
    chk("ovl_ernw", err_rnw, LOG ? 0 : 0);
    chk("ovl_ecnt", err_cnt, LOG ? 3 : 0);

    for (int k = 0; k < 2; k++) begin
      run(2'b11, 1'b1, 0, 0, 20);
      chk($sformatf("sat%0d_first", k), first_low, T + 1);
    end
    chk("sat_ecnt", err_cnt, LOG ? 3 : 0);
    chk("sat_eaddr", err_addr, LOG ? 3 : 0);

    run(2'b10, 1'b0, 0, 0, 5);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tea", tea_reqn, 1);
    chk("mid_rst_ovl", overlap, 0);
    chk("mid_rst_eaddr", err_addr, 0);
    chk("mid_rst_ernw", err_rnw, 0);
    chk("mid_rst_ecnt", err_cnt, 0);
    rst = 1'b0;
    tea_seen = 0;
    for (int i = 0; i < T + 6; i++) begin
      tick();
      if (tea_reqn == 1'b0) tea_seen++;
    end
    chk("mid_rst_no_tea", tea_seen, 0);
    chk("mid_rst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/u111_bus_timeout.md
Name: u111_bus_timeout

Overview:
- Bus-cycle watchdog directly downstream of the U111 data-transfer state machine on the Amiga side of the local bus.
- Consumes the Amiga-side transfer start (TSn) and acknowledge (TACKn), and counts CLK40 cycles per transfer.
- If no acknowledge arrives within a programmable bound, it requests a one-clock bus error (TEA) back to the cycle state machine so the 68040 never hangs on an unmapped access.
- Optionally captures a diagnostic log of timed-out cycles.

Parameters:
- TIMEOUT_CLKS, 256: CLK40 cycles from TSn sample to forced error (6.4 us at 40 MHz); legal range 4..(2^CNT_W - 1).
- CNT_W, 9: width of the cycle counter.
- ERR_CNT_W, 8: width of the saturating timeout event counter.

Ports:
- CLK40  input  1  40 MHz bus clock; the only clock.
- RESET  input  1  synchronous, active-high reset.
- TSn  input  1  Amiga-side transfer start from the cycle state machine; active low, one CLK40 wide.
- TACKn  input  1  Amiga-side transfer acknowledge; active low.
- RnW  input  1  direction of the current transfer; sampled with TSn.
- A_AMIGA  input  2  low address of the current transfer; sampled with TSn.
- BGn  input  1  CPU bus grant; high (bus owned by DMA) disables the watchdog.
- TEA_REQn  output  1  error-termination request to the cycle state machine; active low, one CLK40 wide.
- BUSY  output  1  high while a transfer is being timed.
- OVERLAP  output  1  sticky; set when TSn is sampled while a transfer is already being timed.
- ERR_ADDR  output  2  A_AMIGA of the most recent timed-out cycle (logging only).
- ERR_RNW  output  1  RnW of the most recent timed-out cycle (logging only).
- ERR_CNT  output  ERR_CNT_W  saturating count of timeouts (logging only).

Behaviour:
- All flops are clocked on the rising edge of CLK40. RESET is synchronous, active high, and overrides everything.
- Reset values: TEA_REQn=1, BUSY=0, OVERLAP=0, ERR_ADDR=0, ERR_RNW=0, ERR_CNT=0, counter=0, state=IDLE.
- States: IDLE, ACTIVE, ERROR, RECOVER.
- IDLE:
  - TSn=0 and BGn=0 -> ACTIVE; counter<=0; latch RnW and A_AMIGA; BUSY<=1.
  - TSn=0 with BGn=1 is ignored (DMA cycle, not timed).
- ACTIVE:
  - Counter increments by 1 per clock.
  - TACKn=0 -> IDLE; BUSY<=0; no error.
  - Otherwise counter == TIMEOUT_CLKS-1 -> ERROR.
  - TACKn=0 on the same clock as the terminal count: acknowledge wins, go IDLE, no error.
  - TSn=0 in ACTIVE: OVERLAP<=1 (sticky until RESET); counter restarts at 0; address and RnW are re-latched; stay ACTIVE.
  - BGn rising to 1 mid-transfer -> IDLE; BUSY<=0; no error (ownership lost).
- ERROR:
  - TEA_REQn=0 for exactly one clock; BUSY stays 1.
  - Log update (if enabled).
  - Next state RECOVER.
- RECOVER:
  - BUSY=1; TEA_REQn=1.
  - Wait until TACKn=1 and TSn=1 have been sampled together on one clock, then IDLE; BUSY<=0.
  - This prevents a late acknowledge from being taken as the next cycle's.
- Latency:
  - TEA_REQn asserts TIMEOUT_CLKS+1 clocks after the TSn sample edge.
  - BUSY falls 1 clock after the TACKn sample.
- Counter arithmetic: unsigned CNT_W bits. It never wraps because the terminal compare fires first.
- ERR_CNT saturates at 2^ERR_CNT_W-1 and never wraps.
- RESET mid-transfer: immediate return to reset values; no TEA is issued.

Optional Feature:
- Macro: U111_TIMEOUT_LOG_EN.
- Defined: on entry to ERROR, ERR_ADDR and ERR_RNW take the values latched at TSn, and ERR_CNT increments with saturation.
- Not defined: ERR_ADDR, ERR_RNW and ERR_CNT are constant 0 and no log flops are synthesised.
- TEA behaviour is identical in both builds.

Decomposition:
- Shared package u111_pkg:
  - state encoding typedef (IDLE/ACTIVE/ERROR/RECOVER);
  - default TIMEOUT_CLKS;
  - active-low ASSERTED/NEGATED constants shared with the cycle state machine.
- One sub-module: u111_timeout_log, holding the capture registers and the saturating counter, instantiated only under U111_TIMEOUT_LOG_EN.
- The FSM and the cycle counter stay in the top module.

Test Plan:
- Normal cycle: BGn=0; TSn pulse, TACKn=0 after 5 clocks -> BUSY high for 5 clocks then low one clock after TACKn; TEA_REQn never low; ERR_CNT=0.
- Timeout: TIMEOUT_CLKS=16; TSn with A_AMIGA=2'b10, RnW=1; no TACKn -> TEA_REQn low for exactly one clock, 17 clocks after TSn; ERR_ADDR=2'b10, ERR_RNW=1, ERR_CNT=1 (log build); ERR outputs remain 0 without the macro.
- Race: TACKn=0 on exactly the terminal-count clock -> no TEA_REQn; IDLE next clock.
- Recovery: after a timeout, hold TACKn=0 for 3 clocks -> BUSY stays 1 and a new TSn during RECOVER is not timed; IDLE once TACKn=1 and TSn=1 together.
- Overlap and DMA: second TSn while ACTIVE -> OVERLAP=1 and counter restarts (TEA pushed out by the elapsed clocks); with BGn=1, TSn is ignored (BUSY stays 0); BGn rising mid-cycle aborts silently.
- Reset and saturation: RESET asserted in ACTIVE -> all outputs at reset values next clock, no TEA; ERR_CNT_W=2 with 5 timeouts -> ERR_CNT=3.
